// File: rtl/li_expander_if.sv
// Handshake bundle for the li expander: request side, instruction side and word counter.
// slave is the expander's view; master is the front end / consumer's view.
interface li_expander_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rt;
  logic [31:0]      in_value;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_last;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output in_valid, in_rt, in_value, out_ready,
    input  in_ready, out_valid, out_instr, out_last, instr_count
  );

  modport slave (
    input  in_valid, in_rt, in_value, out_ready,
    output in_ready, out_valid, out_instr, out_last, instr_count
  );
endinterface

// File: rtl/li_expander.sv
// Expands "li rt, value" into LUI and/or ORI instruction words, one word per output handshake.
// A new request is only taken in IDLE, so back-to-back requests see one idle bubble.
module li_expander #(
  parameter bit          OPTIMIZE = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  li_expander_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEmitLui, StEmitOri} state_e;

  localparam logic [5:0] OpLui = 6'h0F;
  localparam logic [5:0] OpOri = 6'h0D;

  state_e           r_state;
  logic [4:0]       r_rt;
  logic [15:0]      r_lo;
  logic [31:0]      r_instr;
  logic             r_last;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic        w_hs;

  assign w_hi = bus.in_value[31:16];
  assign w_lo = bus.in_value[15:0];
  assign w_hs = r_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_rt    <= 5'd0;
      r_lo    <= 16'h0;
      r_instr <= 32'h0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_hs) r_count <= r_count + CNT_W'(1);
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_rt    <= bus.in_rt;
            r_lo    <= w_lo;
            r_valid <= 1'b1;
            // A zero upper half (including value==0) becomes a lone ORI from $0.
            if (OPTIMIZE && (w_hi == 16'h0)) begin
              r_state <= StEmitOri;
              r_instr <= {OpOri, 5'd0, bus.in_rt, w_lo};
              r_last  <= 1'b1;
            end else begin
              r_state <= StEmitLui;
              r_instr <= {OpLui, 5'd0, bus.in_rt, w_hi};
              r_last  <= OPTIMIZE && (w_lo == 16'h0);
            end
          end
        end
        StEmitLui, StEmitOri: begin
          if (bus.out_ready) begin
            if (r_last) begin
              r_state <= StIdle;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_state <= StEmitOri;
              r_instr <= {OpOri, r_rt, r_rt, r_lo};
              r_last  <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == StIdle);
  assign bus.out_valid   = r_valid;
  assign bus.out_instr   = r_instr;
  assign bus.out_last    = r_last;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_li_expander.sv
// Bench for li_expander: table vectors and random requests scored through per-DUT queues,
// plus hand sequences for backpressure, reset mid-sequence and counter wrap.
module tb_li_expander;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  li_expander_if #(.CNT_W(16)) a_if ();
  li_expander_if #(.CNT_W(4))  b_if ();

  li_expander #(.OPTIMIZE(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  li_expander #(.OPTIMIZE(1'b0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  typedef struct {
    logic [4:0]  rt;
    logic [31:0] value;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] exp_cnt_a;
  logic [3:0]  exp_cnt_b;
  logic        bp_en;
  logic        manual_ready;
  logic        rnd_a;
  logic        rnd_b;

  always_comb a_if.out_ready = bp_en ? rnd_a : manual_ready;
  always_comb b_if.out_ready = rnd_b;

  always @(posedge clk) begin
    #1;
    rnd_a = ($urandom_range(0, 3) != 0);
    rnd_b = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit opt, input logic [4:0] rt, input logic [31:0] v,
                                output int n, output logic [31:0] w0, output logic [31:0] w1);
    w1 = {6'b001101, rt, rt, v[15:0]};
    if (opt && v[31:16] == 16'h0) begin
      n  = 1;
      w0 = {6'b001101, 5'b00000, rt, v[15:0]};
    end else begin
      n  = opt && (v[15:0] == 16'h0) ? 1 : 2;
      w0 = {6'b001111, 5'b00000, rt, v[31:16]};
    end
  endfunction

  task automatic push_exp(input bit sel, input int n, input logic [31:0] w0,
                          input logic [31:0] w1);
    exp_t e0;
    exp_t e1;
    e0 = '{instr: w0, last: (n == 1)};
    e1 = '{instr: w1, last: 1'b1};
    if (sel) begin
      q_b.push_back(e0);
      if (n == 2) q_b.push_back(e1);
    end else begin
      q_a.push_back(e0);
      if (n == 2) q_a.push_back(e1);
    end
  endtask

  // Returns at accept edge + 1.
  task automatic send(input bit sel, input logic [4:0] rt, input logic [31:0] v);
    int t = 0;
    @(posedge clk); #1;
    while (!(sel ? b_if.in_ready : a_if.in_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(sel ? b_if.in_ready : a_if.in_ready)) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stuck low, sel=%0d", sel);
      return;
    end
    if (sel) begin
      b_if.in_valid = 1'b1; b_if.in_rt = rt; b_if.in_value = v;
    end else begin
      a_if.in_valid = 1'b1; a_if.in_rt = rt; a_if.in_value = v;
    end
    @(posedge clk); #1;
    a_if.in_valid = 1'b0; a_if.in_rt = 5'($urandom); a_if.in_value = $urandom;
    b_if.in_valid = 1'b0; b_if.in_rt = 5'($urandom); b_if.in_value = $urandom;
  endtask

  task automatic drain(input bit sel);
    int t = 0;
    while (t < 400 && !((sel ? q_b.size() : q_a.size()) == 0 &&
                        (sel ? b_if.in_ready : a_if.in_ready))) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (t >= 400) begin
      n_errors++;
      $display("FAIL drain_timeout: sel=%0d words still pending=%0d", sel,
               sel ? q_b.size() : q_a.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_a.delete();
      exp_cnt_a = '0;
    end else if (a_if.out_valid && a_if.out_ready) begin
      check("a_count", 32'(a_if.instr_count), 32'(exp_cnt_a));
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL a_unexpected: got %08h expected no word", a_if.out_instr);
      end else begin
        e = q_a.pop_front();
        check("a_instr", a_if.out_instr, e.instr);
        check("a_last", 32'(a_if.out_last), 32'(e.last));
      end
      exp_cnt_a = exp_cnt_a + 16'd1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q_b.delete();
      exp_cnt_b = '0;
    end else if (b_if.out_valid && b_if.out_ready) begin
      check("b_count", 32'(b_if.instr_count), 32'(exp_cnt_b));
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL b_unexpected: got %08h expected no word", b_if.out_instr);
      end else begin
        e = q_b.pop_front();
        check("b_instr", b_if.out_instr, e.instr);
        check("b_last", 32'(b_if.out_last), 32'(e.last));
      end
      exp_cnt_b = exp_cnt_b + 4'd1;
    end
  end

  initial begin
    vec_t        tbl[6];
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] v;
    logic [15:0] cnt0;

    tbl[0] = '{rt: 5'd8,  value: 32'h12345678, n: 2, w0: 32'h3C081234, w1: 32'h35085678};
    tbl[1] = '{rt: 5'd9,  value: 32'h0000ABCD, n: 1, w0: 32'h3409ABCD, w1: 32'h0};
    tbl[2] = '{rt: 5'd10, value: 32'hDEAD0000, n: 1, w0: 32'h3C0ADEAD, w1: 32'h0};
    tbl[3] = '{rt: 5'd2,  value: 32'h00000000, n: 1, w0: 32'h34020000, w1: 32'h0};
    tbl[4] = '{rt: 5'd0,  value: 32'hFFFFFFFF, n: 2, w0: 32'h3C00FFFF, w1: 32'h3400FFFF};
    tbl[5] = '{rt: 5'd31, value: 32'h00010000, n: 1, w0: 32'h3C1F0001, w1: 32'h0};

    rst = 1'b1; bp_en = 1'b0; manual_ready = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_rt = '0; a_if.in_value = '0;
    b_if.in_valid = 1'b0; b_if.in_rt = '0; b_if.in_value = '0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_out_instr", a_if.out_instr, 32'h0);
    check("rst_out_last", 32'(a_if.out_last), 32'd0);
    check("rst_count", 32'(a_if.instr_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(a_if.in_ready), 32'd1);
    check("idle_out_valid", 32'(a_if.out_valid), 32'd0);

    // Table vectors, consumer always ready.
    @(posedge clk); #1 manual_ready = 1'b1;
    foreach (tbl[i]) begin
      push_exp(1'b0, tbl[i].n, tbl[i].w0, tbl[i].w1);
      send(1'b0, tbl[i].rt, tbl[i].value);
    end
    drain(1'b0);

    // Backpressure on the first word of a two-word li.
    manual_ready = 1'b0;
    push_exp(1'b0, 2, 32'h3C081234, 32'h35085678);
    send(1'b0, 5'd8, 32'h12345678);
    @(negedge clk);
    check("lat_out_valid", 32'(a_if.out_valid), 32'd1);
    check("lat_out_instr", a_if.out_instr, 32'h3C081234);
    cnt0 = a_if.instr_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_instr", a_if.out_instr, 32'h3C081234);
      check("bp_in_ready", 32'(a_if.in_ready), 32'd0);
      check("bp_count", 32'(a_if.instr_count), 32'(cnt0));
    end
    @(posedge clk); #1 manual_ready = 1'b1;
    drain(1'b0);

    // Random requests under random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v[31:16] = 16'h0;
        1: v[15:0]  = 16'h0;
        2: v = 32'h0;
        default: ;
      endcase
      model(1'b1, 5'($urandom), v, n, w0, w1);
      push_exp(1'b0, n, w0, w1);
      send(1'b0, w0[20:16], v);
    end
    drain(1'b0);
    bp_en = 1'b0;
    manual_ready = 1'b0;

    // Reset while the ORI half is pending.
    push_exp(1'b0, 2, 32'h3C081234, 32'h35085678);
    send(1'b0, 5'd8, 32'h12345678);
    manual_ready = 1'b1;
    @(posedge clk); #1 manual_ready = 1'b0;
    @(negedge clk);
    check("ori_instr", a_if.out_instr, 32'h35085678);
    check("ori_last", 32'(a_if.out_last), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(a_if.in_ready), 32'd1);
    check("mid_rst_count", 32'(a_if.instr_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    manual_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(a_if.out_valid), 32'd0);
    end

    // OPTIMIZE=0, CNT_W=4: eight two-word requests are exactly sixteen handshakes.
    push_exp(1'b1, 2, 32'h3C090000, 32'h3529ABCD);
    send(1'b1, 5'd9, 32'h0000ABCD);
    for (int i = 0; i < 7; i++) begin
      v = (i % 2 == 0) ? {16'h0, 16'($urandom)} : $urandom;
      model(1'b0, 5'($urandom), v, n, w0, w1);
      push_exp(1'b1, n, w0, w1);
      send(1'b1, w0[20:16], v);
    end
    drain(1'b1);
    @(negedge clk);
    check("b_wrap_count", 32'(b_if.instr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
